seg7_frame_capture: RTL and testbench
=====================================

// Module: seg7_frame_capture
// PURPOSE
//   Receive side of our BCD-to-7-segment display path: samples a multiplexed 7-seg bus
//   (one-hot digit select + shared segment lines), debounces each digit dwell, encodes
//   the segment pattern back to BCD and assembles one N_DIGITS frame.
//   Completed frames are offered on a valid/ready port to the downstream checker/logger.
// PARAMETERS
//   N_DIGITS    4   number of multiplexed digits (one-hot select width)
//   STABLE_CYC  4   consecutive identical samples required to accept a digit (>=2)
// PORTS
//   i_clk        in   1           rising-edge clock, sole clock domain
//   i_rst_n      in   1           reset, asynchronous assert, active-low
//   i_seg        in   7           segments, bit0=a .. bit6=g, active-high
//   i_dig_sel    in   N_DIGITS    digit select, active-high, must be one-hot to capture
//   i_ready      in   1           downstream accepts frame
//   i_ovr_clr    in   1           synchronous clear of o_overrun
//   o_valid      out  1           frame available
//   o_bcd        out  4*N_DIGITS  digit k in [4k+3:4k]
//   o_err        out  N_DIGITS    bit k set: digit k pattern not a legal 0-9 code
//   o_overrun    out  1           sticky: a complete frame was dropped
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, stability count 0, slot-filled mask 0, input regs 0.
//   - Inputs registered once (r_seg, r_sel) before any use.
//   - Legal codes (a..g = bit0..6): 0=7'h3F 1=7'h06 2=7'h5B 3=7'h4F 4=7'h66
//     5=7'h6D 6=7'h7D 7=7'h07 8=7'h7F 9=7'h6F. Any other pattern, incl. 0 -> 4'hF, err=1.
//   - FSM per dwell: IDLE -> SETTLE when r_sel one-hot; SETTLE counts while sample equals
//     previous (r_sel,r_seg); any change restarts count at 1 (stay SETTLE if one-hot,
//     else IDLE). Count reaching STABLE_CYC: capture, -> LOCKED. LOCKED holds (no
//     re-capture) until sample changes -> SETTLE (one-hot) or IDLE (not one-hot).
//   - Non-one-hot select (0 or >1 bits) never captures and forces count to 0.
//   - Capture: slot k = index of set r_sel bit; store code+err; set filled[k].
//     Re-capture of a filled slot before frame completes overwrites it (newest wins).
//   - Frame completes in the cycle filled becomes all-ones; filled cleared same edge.
//     If output register free (o_valid=0, or o_valid&i_ready this cycle) it loads
//     o_bcd/o_err and o_valid=1 at the next edge; otherwise frame dropped, o_overrun<=1.
//   - Latency: capture on the STABLE_CYC-th sampling edge of the final digit; o_valid
//     high after the following edge.
//   - Handshake: while o_valid=1 & i_ready=0, o_bcd/o_err/o_valid hold stable. Transfer
//     on o_valid&i_ready; o_valid drops next edge unless a new frame loads same edge.
//   - o_overrun: set on drop, cleared by i_ovr_clr; set wins if both in same cycle.
//   - Async reset mid-frame discards partial frame; next frame needs every digit again.
//   - Count width clog2(STABLE_CYC+1); saturates, never wraps.
// STRUCTURE
//   - Package seg7_pkg: SEG_0..SEG_9 constants (shared with decoder bench), BCD_ERR=4'hF,
//     FSM state encoding IDLE/SETTLE/LOCKED.
//   - Sub-module seg7_to_bcd: combinational 7-bit pattern -> {err, bcd[3:0]}.
//   - Top: input regs, dwell FSM + counter, slot regs + filled mask, output reg/handshake.
// TESTING
//   1 Reset: i_rst_n=0 with toggling inputs -> all outputs 0; release -> still 0.
//   2 Scan sel 0001..1000 with 7'h06,7'h5B,7'h4F,7'h66, 8 cycles each, i_ready=1
//     -> single o_valid pulse, o_bcd=16'h4321, o_err=4'b0000.
//   3 Glitch: digit held 3 cycles then changed -> no capture; held 4 -> captured.
//   4 Digit 2 shows 7'h70 -> o_bcd[11:8]=4'hF, o_err=4'b0100, other digits correct.
//   5 i_ready=0 across two frames -> frame 1 held stable, frame 2 dropped,
//     o_overrun=1 until i_ovr_clr; i_ready=1 then transfers frame 1.
//   6 sel=4'b0011 and 4'b0000 dwells -> no capture; async reset after 2 digits
//     -> partial frame lost, next complete frame reports only new values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path: legal segment codes,
// the BCD error code and the per-dwell FSM state encoding.
package seg7_pkg;

    // Segment patterns, bit0 = a .. bit6 = g, active-high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } dwell_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of a 7-segment pattern back to BCD; any pattern that
// is not one of the ten legal digits maps to BCD_ERR with o_err set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_err
);

    always_comb begin
        case (i_seg)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            default: o_bcd = BCD_ERR;
        endcase
        o_err = (o_bcd == BCD_ERR);
    end

endmodule

// File: rtl/seg7_frame_capture.sv
// Samples a multiplexed 7-seg bus, debounces each digit dwell, decodes it to
// BCD and assembles N_DIGITS-wide frames offered on a valid/ready port.
module seg7_frame_capture
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [6:0]            i_seg,
    input  logic [N_DIGITS-1:0]   i_dig_sel,
    input  logic                  i_ready,
    input  logic                  i_ovr_clr,
    output logic                  o_valid,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic [N_DIGITS-1:0]   o_err,
    output logic                  o_overrun
);

    localparam int                  CNT_W      = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYC);
    localparam logic [N_DIGITS-1:0] SEL_ONE    = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0] ALL_FILLED = '1;

    // Input sample and the sample one cycle earlier.
    logic [6:0]            r_seg_q, r_seg_d, prev_seg_q, prev_seg_d;
    logic [N_DIGITS-1:0]   r_sel_q, r_sel_d, prev_sel_q, prev_sel_d;

    dwell_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [4*N_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [N_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [N_DIGITS-1:0]   filled_q, filled_d;

    logic                  valid_q, valid_d;
    logic [4*N_DIGITS-1:0] out_bcd_q, out_bcd_d;
    logic [N_DIGITS-1:0]   out_err_q, out_err_d;
    logic                  ovr_q, ovr_d;

    logic                  sel_onehot, sample_same, capture;
    logic [CNT_W-1:0]      cnt_next;
    logic [3:0]            dec_bcd;
    logic                  dec_err;
    logic                  frame_done, out_free, load, drop;

    seg7_to_bcd u_dec (
        .i_seg (r_seg_q),
        .o_bcd (dec_bcd),
        .o_err (dec_err)
    );

    always_comb begin
        r_seg_d    = i_seg;
        r_sel_d    = i_dig_sel;
        prev_seg_d = r_seg_q;
        prev_sel_d = r_sel_q;
    end

    assign sel_onehot  = (r_sel_q != '0) && ((r_sel_q & (r_sel_q - SEL_ONE)) == '0);
    assign sample_same = (r_sel_q == prev_sel_q) && (r_seg_q == prev_seg_q);
    assign cnt_next    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_ONE;

    // Dwell FSM: a digit is accepted once, after STABLE_CYC identical samples.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_onehot) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!sample_same) begin
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_next;
                    if (cnt_next == CNT_LAST) begin
                        capture = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!sample_same) begin
                    state_d = sel_onehot ? SETTLE : IDLE;
                    cnt_d   = sel_onehot ? CNT_ONE : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign frame_done = (filled_q == ALL_FILLED);
    assign out_free   = !valid_q || i_ready;
    assign load       = frame_done && out_free;
    assign drop       = frame_done && !out_free;

    // Slot storage: a capture landing in the completion cycle starts the next frame.
    always_comb begin
        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        filled_d   = frame_done ? '0 : filled_q;
        if (capture) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (r_sel_q[k]) begin
                    slot_bcd_d[4*k +: 4] = dec_bcd;
                    slot_err_d[k]        = dec_err;
                    filled_d[k]          = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        out_bcd_d = out_bcd_q;
        out_err_d = out_err_q;
        if (load) begin
            valid_d   = 1'b1;
            out_bcd_d = slot_bcd_q;
            out_err_d = slot_err_q;
        end else if (valid_q && i_ready) begin
            valid_d   = 1'b0;
        end
        ovr_d = drop ? 1'b1 : (i_ovr_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_q    <= '0;
            r_sel_q    <= '0;
            prev_seg_q <= '0;
            prev_sel_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            // NOTE: slot contents are reset too; the register count is tiny and it keeps o_bcd deterministic.
            slot_bcd_q <= '0;
            slot_err_q <= '0;
            filled_q   <= '0;
            valid_q    <= 1'b0;
            out_bcd_q  <= '0;
            out_err_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_seg_q    <= r_seg_d;
            r_sel_q    <= r_sel_d;
            prev_seg_q <= prev_seg_d;
            prev_sel_q <= prev_sel_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_bcd_q <= slot_bcd_d;
            slot_err_q <= slot_err_d;
            filled_q   <= filled_d;
            valid_q    <= valid_d;
            out_bcd_q  <= out_bcd_d;
            out_err_q  <= out_err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_bcd     = out_bcd_q;
    assign o_err     = out_err_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed bench for seg7_frame_capture: a run-length reference model is
// compared against the DUT on every falling edge, plus literal frame checks.
module tb_seg7_frame_capture;

    localparam int N  = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic        ready;
    logic        ovr_clr;
    logic        o_valid;
    logic [15:0] o_bcd;
    logic [3:0]  o_err;
    logic        o_overrun;

    always #5 clk = ~clk;

    seg7_frame_capture #(.N_DIGITS(N), .STABLE_CYC(SC)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_seg     (seg),
        .i_dig_sel (sel),
        .i_ready   (ready),
        .i_ovr_clr (ovr_clr),
        .o_valid   (o_valid),
        .o_bcd     (o_bcd),
        .o_err     (o_err),
        .o_overrun (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [6:0] legal [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (p == legal[i]) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    // Reference model: a digit is accepted when the same one-hot input sample
    // has been seen SC times in a row; the input register delays its effect by
    // one edge and the frame reaches the output one edge after completion.
    logic [6:0]  m_last_seg = '0;
    logic [3:0]  m_last_sel = '0;
    int          m_run = 0;
    logic        m_pend = 1'b0;
    logic [3:0]  m_pend_sel = '0;
    logic [6:0]  m_pend_seg = '0;
    logic [3:0]  m_slot_bcd [N];
    logic        m_slot_err [N];
    logic [3:0]  m_filled = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_bcd = '0;
    logic [3:0]  m_err = '0;
    logic        m_ovr = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit         complete, dropped;
        logic [4:0] d;
        if (!rst_n) begin
            m_last_seg = '0; m_last_sel = '0; m_run = 0; m_pend = 1'b0;
            m_filled = '0; m_valid = 1'b0; m_bcd = '0; m_err = '0; m_ovr = 1'b0;
            for (int k = 0; k < N; k++) begin
                m_slot_bcd[k] = '0;
                m_slot_err[k] = 1'b0;
            end
        end else begin
            complete = (m_filled == 4'b1111);
            dropped  = 1'b0;
            if (complete) begin
                if (!m_valid || ready) begin
                    m_valid = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        m_bcd[4*k +: 4] = m_slot_bcd[k];
                        m_err[k]        = m_slot_err[k];
                    end
                end else begin
                    dropped = 1'b1;
                end
                m_filled = '0;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (dropped) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            if (m_pend) begin
                d = ref_decode(m_pend_seg);
                for (int k = 0; k < N; k++) begin
                    if (m_pend_sel[k]) begin
                        m_slot_bcd[k] = d[3:0];
                        m_slot_err[k] = d[4];
                        m_filled[k]   = 1'b1;
                    end
                end
            end
            m_pend = 1'b0;
            if (sel == m_last_sel && seg == m_last_seg) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            if ($countones(sel) == 1 && m_run == SC) begin
                m_pend     = 1'b1;
                m_pend_sel = sel;
                m_pend_seg = seg;
            end
            m_last_sel = sel;
            m_last_seg = seg;
        end
    end

    int          valid_cycles = 0;
    logic [15:0] last_bcd = '0;
    logic [3:0]  last_err = '0;

    always @(negedge clk) begin
        check("valid", o_valid, m_valid);
        check("bcd", o_bcd, m_bcd);
        check("err", o_err, m_err);
        check("overrun", o_overrun, m_ovr);
        if (o_valid) begin
            valid_cycles++;
            last_bcd = o_bcd;
            last_err = o_err;
        end
    end

    task automatic dwell(input logic [3:0] s, input logic [6:0] p, input int n);
        sel = s;
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_bcd"}, o_bcd, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_ovr"}, o_overrun, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ready = 1'b0; ovr_clr = 1'b0; sel = '0; seg = '0;

        // Reset with toggling inputs
        repeat (5) begin
            @(negedge clk);
            check_zero("rst");
            sel = 4'($urandom); seg = 7'($urandom);
            ready = 1'($urandom); ovr_clr = 1'($urandom);
        end
        sel = '0; seg = '0; ready = 1'b1; ovr_clr = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("post_rst");

        // Straight scan of 1,2,3,4
        valid_cycles = 0;
        dwell(4'b0001, 7'h06, 8); dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h4F, 8); dwell(4'b1000, 7'h66, 8);
        dwell(4'b0000, 7'h00, 6);
        check("scan_pulses", valid_cycles, 1);
        check("scan_bcd", last_bcd, 16'h4321);
        check("scan_err", last_err, 4'b0000);

        // Glitches: 3-cycle dwells are ignored, 4-cycle dwells are captured
        valid_cycles = 0;
        dwell(4'b0001, 7'h4F, 3); dwell(4'b0010, 7'h06, 4);
        dwell(4'b0100, 7'h7D, 3); dwell(4'b0100, 7'h6D, 4);
        dwell(4'b1000, 7'h07, 4); dwell(4'b0001, 7'h3F, 4);
        dwell(4'b0000, 7'h00, 6);
        check("glitch_pulses", valid_cycles, 1);
        check("glitch_bcd", last_bcd, 16'h7510);
        check("glitch_err", last_err, 4'b0000);

        // Illegal pattern on digit 2
        valid_cycles = 0;
        dwell(4'b0001, 7'h6D, 6); dwell(4'b0010, 7'h7F, 6);
        dwell(4'b0100, 7'h70, 6); dwell(4'b1000, 7'h6F, 6);
        dwell(4'b0000, 7'h00, 6);
        check("illegal_pulses", valid_cycles, 1);
        check("illegal_bcd", last_bcd, 16'h9F85);
        check("illegal_err", last_err, 4'b0100);

        // Back-pressure: frame 1 held, frame 2 dropped
        ready = 1'b0;
        dwell(4'b0001, 7'h3F, 6); dwell(4'b0010, 7'h06, 6);
        dwell(4'b0100, 7'h5B, 6); dwell(4'b1000, 7'h4F, 6);
        dwell(4'b0001, 7'h66, 6); dwell(4'b0010, 7'h6D, 6);
        dwell(4'b0100, 7'h7D, 6); dwell(4'b1000, 7'h07, 6);
        dwell(4'b0000, 7'h00, 4);
        check("bp_valid", o_valid, 1);
        check("bp_bcd", o_bcd, 16'h3210);
        check("bp_err", o_err, 4'b0000);
        check("bp_ovr", o_overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("bp_ovr_clr", o_overrun, 0);
        check("bp_hold", o_valid, 1);
        ready = 1'b1;
        @(negedge clk);
        check("bp_xfer", o_valid, 0);
        repeat (2) @(negedge clk);

        // Non-one-hot dwells, then async reset mid-frame
        valid_cycles = 0;
        dwell(4'b0011, 7'h6D, 6); dwell(4'b0000, 7'h6D, 6);
        dwell(4'b0100, 7'h5B, 6); dwell(4'b1000, 7'h4F, 6);
        check("partial_pulses", valid_cycles, 0);
        #3 rst_n = 1'b0;
        sel = '0; seg = '0;
        repeat (2) @(negedge clk);
        check_zero("mid_rst");
        rst_n = 1'b1;
        dwell(4'b0001, 7'h66, 6); dwell(4'b0010, 7'h6D, 6);
        dwell(4'b0100, 7'h7D, 6); dwell(4'b1000, 7'h07, 6);
        dwell(4'b0000, 7'h00, 6);
        check("after_rst_pulses", valid_cycles, 1);
        check("after_rst_bcd", last_bcd, 16'h7654);
        check("after_rst_err", last_err, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
